// File: rtl/mem_access_stage_if.sv
// Bus between the EX/MEM register, the MEM stage and the MEM/WB register.
// Handshake: the producer holds every request field stable while stall=1; a result is taken from MEM/WB only in a cycle with valid_out=1.
interface mem_access_stage_if;
  logic        in_valid;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  size_in;
  logic        sign_in;
  logic [1:0]  WB_in;
  logic [31:0] ALUresult_in;
  logic [31:0] Writedata_in;
  logic [4:0]  Insaddr_in;

  logic        stall;
  logic        valid_out;
  logic [1:0]  WB_out;
  logic [31:0] ALUresult_out;
  logic [31:0] Readdata_out;
  logic [4:0]  Insaddr_out;
  logic        err_out;

  logic        dbg_wait;
  logic [3:0]  dbg_cnt;

  modport slave (
    input  in_valid, MemRead, MemWrite, size_in, sign_in, WB_in,
           ALUresult_in, Writedata_in, Insaddr_in,
    output stall, valid_out, WB_out, ALUresult_out, Readdata_out,
           Insaddr_out, err_out, dbg_wait, dbg_cnt
  );

  modport master (
    output in_valid, MemRead, MemWrite, size_in, sign_in, WB_in,
           ALUresult_in, Writedata_in, Insaddr_in,
    input  stall, valid_out, WB_out, ALUresult_out, Readdata_out,
           Insaddr_out, err_out, dbg_wait, dbg_cnt
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: word RAM with a MEM_LAT wait-state FSM that stalls upstream.
// Define MEM_BYTE_EN for byte/half accesses with sign extension and misalignment flagging.
module mem_access_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic reset,
  mem_access_stage_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         HAS_WAIT = (MEM_LAT > 0);
  localparam logic [3:0] LAT_M1   = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              memop, is_load, is_store;
  logic              stall, complete, misaligned, wr_en;
  logic [3:0]        wmask;
  logic [31:0]       wdata, rd_word, ld_data;
  logic              valid_q, err_q;
  logic [1:0]        wb_q;
  logic [31:0]       alu_q, rdata_q;
  logic [4:0]        ins_q;
  logic              unused_bits;

  assign idx      = bus.ALUresult_in[ADDR_W+1:2];
  assign memop    = bus.in_valid & (bus.MemRead | bus.MemWrite);
  assign is_store = memop & bus.MemWrite;
  assign is_load  = memop & bus.MemRead & ~bus.MemWrite;
  assign rd_word  = ram[idx];

  // An in_valid drop during WAIT is an abort: neither stall nor complete.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (memop && HAS_WAIT) stall = 1'b1;
        else                   complete = 1'b1;
      end
      WAIT: begin
        if (bus.in_valid) begin
          if (cnt != 4'd0) stall = 1'b1;
          else             complete = 1'b1;
        end
      end
      default: ;
    endcase
    if (reset) stall = 1'b0;
  end

`ifdef MEM_BYTE_EN
  logic [1:0]  lane;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane        = bus.ALUresult_in[1:0];
  assign unused_bits = ^bus.ALUresult_in[31:ADDR_W+2];

  // Little-endian lanes; stores replicate the data across lanes and let wmask pick.
  always_comb begin
    misaligned = 1'b0;
    wmask      = 4'hF;
    wdata      = bus.Writedata_in;
    ld_data    = rd_word;
    shifted    = rd_word >> {lane, 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.size_in)
      2'b00: begin
        wmask   = 4'b0001 << lane;
        wdata   = {4{bus.Writedata_in[7:0]}};
        ld_data = {{24{bus.sign_in & byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        misaligned = lane[0];
        wmask      = lane[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{bus.Writedata_in[15:0]}};
        ld_data    = {{16{bus.sign_in & half_sel[15]}}, half_sel};
      end
      default: misaligned = (lane != 2'b00);
    endcase
  end
`else
  assign misaligned  = 1'b0;
  assign wmask       = 4'hF;
  assign wdata       = bus.Writedata_in;
  assign ld_data     = rd_word;
  assign unused_bits = ^{bus.ALUresult_in[31:ADDR_W+2], bus.ALUresult_in[1:0],
                         bus.size_in, bus.sign_in};
`endif

  assign wr_en = complete & is_store & ~misaligned;

  // RAM is not reset; a clock edge coinciding with reset must not commit a store.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wb_q    <= 2'b00;
      alu_q   <= 32'd0;
      rdata_q <= 32'd0;
      ins_q   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && HAS_WAIT) begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (!bus.in_valid)      state <= IDLE;
          else if (cnt != 4'd0)   cnt   <= cnt - 4'd1;
          else                    state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (complete) begin
        valid_q <= bus.in_valid;
        wb_q    <= bus.in_valid ? {bus.WB_in[1] & ~(memop & misaligned), bus.WB_in[0]} : 2'b00;
        alu_q   <= bus.ALUresult_in;
        ins_q   <= bus.Insaddr_in;
        rdata_q <= (is_load && !misaligned) ? ld_data : 32'd0;
        err_q   <= memop & misaligned;
      end else begin
        valid_q <= 1'b0;
        wb_q    <= 2'b00;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.stall         = stall;
  assign bus.valid_out     = valid_q;
  assign bus.WB_out        = wb_q;
  assign bus.ALUresult_out = alu_q;
  assign bus.Readdata_out  = rdata_q;
  assign bus.Insaddr_out   = ins_q;
  assign bus.err_out       = err_q;
  assign bus.dbg_wait      = (state == WAIT);
  assign bus.dbg_cnt       = cnt;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a MEM_LAT=2 instance checked through a scoreboard and a MEM_LAT=0 instance driven from a vector table.
module tb_mem_access_stage;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [70:0] exp_q[$];

  typedef struct {
    logic        v, rd, wr;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  wb;
    logic [31:0] alu, wd;
    logic [4:0]  ins;
    logic [1:0]  e_wb;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  mem_access_stage_if bus2();
  mem_access_stage_if bus0();

  mem_access_stage #(.ADDR_W(8), .MEM_LAT(2)) dut2 (.clk(clk), .reset(rst), .bus(bus2.slave));
  mem_access_stage #(.ADDR_W(8), .MEM_LAT(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0.slave));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mv(input logic v, rd, wr, input logic [1:0] size, input logic sgn,
                              input logic [1:0] wb, input logic [31:0] alu, wd, input logic [4:0] ins,
                              input logic [1:0] e_wb, input logic [31:0] e_rd, input logic e_err);
    vec_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.size = size; t.sgn = sgn; t.wb = wb;
    t.alu = alu; t.wd = wd; t.ins = ins; t.e_wb = e_wb; t.e_rd = e_rd; t.e_err = e_err;
    return t;
  endfunction

  // driver tasks
  task automatic drive2(input logic v, rd, wr, input logic [1:0] wb,
                        input logic [31:0] alu, wd, input logic [4:0] ins);
    bus2.in_valid = v; bus2.MemRead = rd; bus2.MemWrite = wr;
    bus2.size_in = 2'b10; bus2.sign_in = 1'b0; bus2.WB_in = wb;
    bus2.ALUresult_in = alu; bus2.Writedata_in = wd; bus2.Insaddr_in = ins;
  endtask

  task automatic drive0(input vec_t t);
    bus0.in_valid = t.v; bus0.MemRead = t.rd; bus0.MemWrite = t.wr;
    bus0.size_in = t.size; bus0.sign_in = t.sgn; bus0.WB_in = t.wb;
    bus0.ALUresult_in = t.alu; bus0.Writedata_in = t.wd; bus0.Insaddr_in = t.ins;
  endtask

  // Called at posedge+1; returns at the next posedge+1 so ops run back to back.
  task automatic op0(input vec_t t, input string name);
    drive0(t);
    @(negedge clk);
    check({name, "_stall"}, 32'(bus0.stall), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(bus0.valid_out), 32'(t.v));
    check({name, "_wb"}, 32'(bus0.WB_out), 32'(t.e_wb));
    check({name, "_err"}, 32'(bus0.err_out), 32'(t.e_err));
    if (t.v) begin
      check({name, "_alu"}, bus0.ALUresult_out, t.alu);
      check({name, "_rdata"}, bus0.Readdata_out, t.e_rd);
      check({name, "_ins"}, 32'(bus0.Insaddr_out), 32'(t.ins));
    end
  endtask

  task automatic op2(input logic rd, wr, input logic [1:0] wb, input logic [31:0] alu, wd,
                     input logic [4:0] ins, input logic [31:0] e_rd, input int e_stall, input string name);
    int n;
    @(posedge clk); #1;
    drive2(1'b1, rd, wr, wb, alu, wd, ins);
    exp_q.push_back({wb, alu, e_rd, ins});
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus2.stall) break;
      n++;
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(e_stall));
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(bus2.valid_out), 32'd1);
    drive2(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
  endtask

  // scoreboard for the MEM_LAT=2 instance
  always @(negedge clk) begin
    logic [70:0] e;
    if (!rst && bus2.valid_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got valid_out=1 expected no result pending");
      end else begin
        e = exp_q.pop_front();
        check("sb_wb", 32'(bus2.WB_out), 32'(e[70:69]));
        check("sb_alu", bus2.ALUresult_out, e[68:37]);
        check("sb_rdata", bus2.Readdata_out, e[36:5]);
        check("sb_ins", 32'(bus2.Insaddr_out), 32'(e[4:0]));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    drive2(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    drive0(mv(0, 0, 0, 2'b10, 0, 2'b00, 32'd0, 32'd0, 5'd0, 2'b00, 32'd0, 0));

    // word-only vectors, applied back to back on the zero-latency instance
    tbl.push_back(mv(1, 0, 0, 2'b10, 0, 2'b10, 32'h1234, 32'h0, 5'd5, 2'b10, 32'h0, 0));
    tbl.push_back(mv(1, 0, 1, 2'b10, 0, 2'b00, 32'h40, 32'h11111111, 5'd0, 2'b00, 32'h0, 0));
    tbl.push_back(mv(1, 0, 1, 2'b10, 0, 2'b00, 32'h44, 32'h22222222, 5'd0, 2'b00, 32'h0, 0));
    tbl.push_back(mv(1, 1, 0, 2'b10, 0, 2'b11, 32'h40, 32'h0, 5'd7, 2'b11, 32'h11111111, 0));
    tbl.push_back(mv(1, 0, 1, 2'b10, 0, 2'b00, 32'h40, 32'h33333333, 5'd0, 2'b00, 32'h0, 0));
    tbl.push_back(mv(1, 1, 0, 2'b10, 0, 2'b11, 32'h40, 32'h0, 5'd8, 2'b11, 32'h33333333, 0));
    tbl.push_back(mv(1, 1, 0, 2'b10, 0, 2'b11, 32'h44, 32'h0, 5'd9, 2'b11, 32'h22222222, 0));
    tbl.push_back(mv(0, 1, 0, 2'b10, 0, 2'b11, 32'h99, 32'h0, 5'd3, 2'b00, 32'h0, 0));
    tbl.push_back(mv(1, 1, 1, 2'b10, 0, 2'b11, 32'h48, 32'h44444444, 5'd4, 2'b11, 32'h0, 0));
    tbl.push_back(mv(1, 1, 0, 2'b10, 0, 2'b11, 32'h48, 32'h0, 5'd6, 2'b11, 32'h44444444, 0));
    tbl.push_back(mv(1, 0, 1, 2'b10, 0, 2'b00, 32'h440, 32'h55555555, 5'd0, 2'b00, 32'h0, 0));
    tbl.push_back(mv(1, 1, 0, 2'b10, 0, 2'b11, 32'h40, 32'h0, 5'd1, 2'b11, 32'h55555555, 0));
`ifndef MEM_BYTE_EN
    tbl.push_back(mv(1, 1, 0, 2'b11, 1, 2'b11, 32'h43, 32'h0, 5'd2, 2'b11, 32'h55555555, 0));
`endif

    // reset state, with an in-flight request held at the inputs during reset
    #1 rst = 1'b1;
    drive2(1'b1, 1'b1, 1'b0, 2'b11, 32'h10, 32'h0, 5'd1);
    #2;
    check("rst_valid", 32'(bus2.valid_out), 32'd0);
    check("rst_wb", 32'(bus2.WB_out), 32'd0);
    check("rst_alu", bus2.ALUresult_out, 32'd0);
    check("rst_rdata", bus2.Readdata_out, 32'd0);
    check("rst_ins", 32'(bus2.Insaddr_out), 32'd0);
    check("rst_err", 32'(bus2.err_out), 32'd0);
    check("rst_stall", 32'(bus2.stall), 32'd0);
    check("rst_state", 32'(bus2.dbg_wait), 32'd0);
    check("rst0_valid", 32'(bus0.valid_out), 32'd0);
    drive2(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #2 rst = 1'b0;

    // table on MEM_LAT=0: stall never rises, one result per cycle
    @(posedge clk); #1;
    foreach (tbl[i]) op0(tbl[i], $sformatf("vec%0d", i));

`ifdef MEM_BYTE_EN
    op0(mv(1, 0, 1, 2'b10, 0, 2'b00, 32'h30, 32'h11223344, 5'd0, 2'b00, 32'h0, 0), "be_word_st");
    op0(mv(1, 0, 1, 2'b00, 0, 2'b00, 32'h31, 32'h000000AB, 5'd0, 2'b00, 32'h0, 0), "be_byte_st");
    op0(mv(1, 1, 0, 2'b10, 0, 2'b11, 32'h30, 32'h0, 5'd2, 2'b11, 32'h1122AB44, 0), "be_word_ld");
    op0(mv(1, 1, 0, 2'b00, 1, 2'b11, 32'h31, 32'h0, 5'd3, 2'b11, 32'hFFFFFFAB, 0), "be_sbyte_ld");
    op0(mv(1, 1, 0, 2'b01, 0, 2'b11, 32'h32, 32'h0, 5'd4, 2'b11, 32'h00001122, 0), "be_uhalf_ld");
    op0(mv(1, 0, 1, 2'b01, 0, 2'b10, 32'h33, 32'h0000FFFF, 5'd5, 2'b00, 32'h0, 1), "be_mis_st");
    op0(mv(1, 0, 0, 2'b10, 0, 2'b10, 32'h7, 32'h0, 5'd6, 2'b10, 32'h0, 0), "be_err_clr");
    op0(mv(1, 1, 0, 2'b10, 0, 2'b11, 32'h30, 32'h0, 5'd7, 2'b11, 32'h1122AB44, 0), "be_word_chk");
`endif
    drive0(mv(0, 0, 0, 2'b10, 0, 2'b00, 32'd0, 32'd0, 5'd0, 2'b00, 32'd0, 0));

    // MEM_LAT=2 store then load, and a non-memory op
    op2(1'b0, 1'b1, 2'b11, 32'h10, 32'hDEADBEEF, 5'd3, 32'h0, 2, "l2_store");
    op2(1'b1, 1'b0, 2'b11, 32'h10, 32'h0, 5'd3, 32'hDEADBEEF, 2, "l2_load");
    op2(1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd5, 32'h0, 0, "l2_nonmem");

    // reset in the middle of a store's wait states
    op2(1'b0, 1'b1, 2'b00, 32'h20, 32'h0BADC0DE, 5'd0, 32'h0, 2, "l2_old_st");
    @(posedge clk); #1;
    drive2(1'b1, 1'b0, 1'b1, 2'b11, 32'h20, 32'hCAFEF00D, 5'd9);
    @(posedge clk); #2;
    check("abort_pre_wait", 32'(bus2.dbg_wait), 32'd1);
    check("abort_pre_stall", 32'(bus2.stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_state", 32'(bus2.dbg_wait), 32'd0);
    check("abort_valid", 32'(bus2.valid_out), 32'd0);
    check("abort_alu", bus2.ALUresult_out, 32'd0);
    check("abort_wb", 32'(bus2.WB_out), 32'd0);
    check("abort_cnt", 32'(bus2.dbg_cnt), 32'd0);
    drive2(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #2 rst = 1'b0;
    op2(1'b1, 1'b0, 2'b11, 32'h20, 32'h0, 5'd11, 32'h0BADC0DE, 2, "l2_after_abort");

    // in_valid dropped during WAIT: back to IDLE, store discarded
    op2(1'b0, 1'b1, 2'b00, 32'h30, 32'h66666666, 5'd0, 32'h0, 2, "l2_st66");
    @(posedge clk); #1;
    drive2(1'b1, 1'b0, 1'b1, 2'b11, 32'h30, 32'h77777777, 5'd12);
    @(posedge clk); #1;
    check("drop_in_wait", 32'(bus2.dbg_wait), 32'd1);
    drive2(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    check("drop_state", 32'(bus2.dbg_wait), 32'd0);
    check("drop_valid", 32'(bus2.valid_out), 32'd0);
    op2(1'b1, 1'b0, 2'b11, 32'h30, 32'h0, 5'd13, 32'h66666666, 2, "l2_ld66");

    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Takes the ALU result (used as the address), the store data and control bits from EX/MEM, and performs a data-memory access against an internal word RAM.
- Drives the registered ALU result, load data, WB control and destination register number into MEM/WB.
- Models a multi-cycle data memory: a wait-state FSM stalls the upstream pipeline while a load or store is in flight.

Parameters:
- ADDR_W, 8: word-address width; RAM holds 2^ADDR_W 32-bit words.
- MEM_LAT, 2: wait states per memory op (0..15). A memory op occupies MEM_LAT+1 cycles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- MemRead  in  1  load request
- MemWrite  in  1  store request
- size_in  in  2  access size: 00 byte, 01 half, 10 word (decoded only with MEM_BYTE_EN)
- sign_in  in  1  sign-extend sub-word loads (decoded only with MEM_BYTE_EN)
- WB_in  in  2  [1] RegWrite, [0] MemtoReg
- ALUresult_in  in  32  ALU result; byte address for memory ops
- Writedata_in  in  32  store data
- Insaddr_in  in  5  destination register number
- stall  out  1  hold EX/MEM and all earlier stages
- valid_out  out  1  MEM/WB inputs are valid this cycle
- WB_out  out  2  registered WB control
- ALUresult_out  out  32  registered ALU result
- Readdata_out  out  32  registered load data
- Insaddr_out  out  5  registered destination register
- err_out  out  1  misaligned access flagged (MEM_BYTE_EN only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous): FSM to IDLE, counter to 0, all outputs 0. RAM contents are not reset.
- memop = in_valid & (MemRead | MemWrite). If MemRead and MemWrite are both high, the op is treated as a store and Readdata_out is 0.
- Word index = ALUresult_in[ADDR_W+1:2]. Address bits above that are ignored; the index wraps modulo depth.
- FSM states: IDLE, WAIT; 4-bit counter cnt.
- IDLE, no memop: complete this cycle, stall=0.
- IDLE, memop, MEM_LAT=0: complete this cycle, stall=0.
- IDLE, memop, MEM_LAT>0: stall=1, go to WAIT, cnt <= MEM_LAT-1.
- WAIT, cnt!=0: stall=1, cnt <= cnt-1.
- WAIT, cnt==0: stall=0, complete, go to IDLE.
- stall is combinational from state, cnt and the inputs. Upstream must hold all inputs stable while stall=1; the stage does not latch the request.
- Complete (at the clock edge):
  - WB_out, ALUresult_out and Insaddr_out <= inputs.
  - valid_out <= in_valid.
  - Readdata_out <= RAM word for a load, else 0.
  - Store writes the RAM at this edge.
  - Read-during-write is not possible: there is one op per completion.
- Not completing (stall=1): valid_out <= 0 and WB_out <= 0 (bubble into MEM/WB); other outputs hold.
- in_valid=0 in IDLE: valid_out <= 0, WB_out <= 0, no RAM access.
- in_valid dropping while in WAIT is a protocol violation. Required behaviour: return to IDLE next edge, no RAM write, valid_out=0.
- Reset asserted in WAIT: abort immediately; any pending store is lost.
- Latency: non-memory instruction 1 cycle; memory op MEM_LAT+1 cycles to valid_out.

Optional Feature:
- MEM_BYTE_EN defined:
  - size_in / sign_in are decoded, little-endian lane select by ALUresult_in[1:0].
  - Byte/half stores update only the selected lanes (read-modify-write at the completing edge).
  - Loads are zero- or sign-extended per sign_in.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]!=0): store suppressed, Readdata_out=0, WB_out[1] forced 0, err_out=1 for the completing cycle only.
  - size_in=11 is treated as word.
- MEM_BYTE_EN undefined:
  - Word-only access; addr[1:0], size_in and sign_in are ignored.
  - err_out is tied to 0.

Test Plan:
- MEM_LAT=2, store 0xDEADBEEF @0x10, then load @0x10 -> stall high for 2 cycles per op, valid_out 3 cycles after each op is presented, Readdata_out=0xDEADBEEF, WB_out=2'b11 passed through.
- Non-memory op (ALUresult_in=0x1234, Insaddr_in=5, WB_in=2'b10) -> stall=0, next cycle ALUresult_out=0x1234, Insaddr_out=5, Readdata_out=0.
- MEM_LAT=0, back-to-back load/store/load -> stall never asserts, one result per cycle.
- reset pulsed mid-WAIT of a store to 0x20 -> outputs 0, FSM IDLE, later load @0x20 returns the old value.
- MEM_BYTE_EN: store byte 0xAB @0x31 onto word 0x11223344, signed byte load @0x31 -> word reads 0x1122AB44, load returns 0xFFFFFFAB.
- MEM_BYTE_EN: half store @0x33 -> err_out=1 for one cycle, RAM unchanged, WB_out[1]=0.
